// File: rtl/executing_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO for the MIPS execute stage.
// One bit per cycle: shift-add multiply, restoring divide, then a sign-fix cycle and a write-back cycle.
module executing_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             startInput,
   input  logic [1:0]       opInput,
   input  logic [WIDTH-1:0] operandAInput,
   input  logic [WIDTH-1:0] operandBInput,
   input  logic             hiLoWriteInput,
   input  logic             hiLoSelInput,
   input  logic [WIDTH-1:0] hiLoWriteDataInput,
   input  logic             flushInput,
   output logic             busyOutput,
   output logic             doneOutput,
   output logic             divByZeroOutput,
   output logic [WIDTH-1:0] hiOutput,
   output logic [WIDTH-1:0] loOutput
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, WB} state_t;

   state_t             state;
   logic [WIDTH-1:0]   hi_reg, lo_reg;
   logic [WIDTH-1:0]   p_hi, p_lo;   // {P_hi,P_lo} for multiply, {R,Q} for divide
   logic [WIDTH-1:0]   b_reg;        // multiplicand or divisor magnitude
   logic [CNT_W-1:0]   cnt;
   logic               op_div, neg_q, neg_r;
   logic               busy_r, done_r, dbz_r;

   // Operand decode for a request presented this cycle
   logic               is_signed, is_div, sign_a, sign_b, b_zero, accept;
   logic [WIDTH-1:0]   mag_a, mag_b;

   always_comb begin
      is_signed = ~opInput[0];
      is_div    = opInput[1];
      sign_a    = is_signed & operandAInput[WIDTH-1];
      sign_b    = is_signed & operandBInput[WIDTH-1];
      mag_a     = sign_a ? (~operandAInput + 1'b1) : operandAInput;
      mag_b     = sign_b ? (~operandBInput + 1'b1) : operandBInput;
      b_zero    = is_div && (operandBInput == '0);
      accept    = startInput && !flushInput && (state == IDLE || state == WB);
   end

   // Single-iteration datapath
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] prod_neg;

   always_comb begin
      mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
      div_sh    = {p_hi, p_lo[WIDTH-1]};
      div_trial = div_sh - {1'b0, b_reg};
      prod_neg  = ~{p_hi, p_lo} + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         hi_reg <= '0;
         lo_reg <= '0;
         p_hi   <= '0;
         p_lo   <= '0;
         b_reg  <= '0;
         cnt    <= '0;
         op_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
         case (state)
            IDLE: begin
               if (hiLoWriteInput) begin
                  if (hiLoSelInput) hi_reg <= hiLoWriteDataInput;
                  else              lo_reg <= hiLoWriteDataInput;
               end
            end
            RUN: begin
               if (flushInput) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end else begin
                  if (op_div) begin
                     // Restoring step: keep the trial difference only when it did not borrow
                     p_hi <= div_trial[WIDTH] ? div_sh[WIDTH-1:0] : div_trial[WIDTH-1:0];
                     p_lo <= {p_lo[WIDTH-2:0], ~div_trial[WIDTH]};
                  end else begin
                     p_hi <= mul_sum[WIDTH:1];
                     p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
                  end
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) state <= FIX;
               end
            end
            FIX: begin
               if (flushInput) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end else begin
                  if (!op_div && neg_q) {p_hi, p_lo} <= prod_neg;
                  if (op_div && neg_q)  p_lo <= ~p_lo + 1'b1;
                  if (op_div && neg_r)  p_hi <= ~p_hi + 1'b1;
                  state  <= WB;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end
            end
            WB: begin
               hi_reg <= p_hi;
               lo_reg <= p_lo;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Launch overrides the per-state next-state above; WB commits at the same edge.
         if (accept) begin
            op_div <= is_div;
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            cnt    <= CNT_W'(WIDTH);
            p_hi   <= '0;
            if (is_div) begin
               p_lo  <= mag_a;
               b_reg <= mag_b;
            end else begin
               p_lo  <= mag_b;
               b_reg <= mag_a;
            end
            if (b_zero) begin
               // Divide by zero skips the iterations: LO all ones, HI the raw dividend
               p_hi   <= operandAInput;
               p_lo   <= '1;
               state  <= WB;
               busy_r <= 1'b0;
               done_r <= 1'b1;
               dbz_r  <= 1'b1;
            end else begin
               state  <= RUN;
               busy_r <= 1'b1;
            end
         end
      end
   end

   assign busyOutput      = busy_r;
   assign doneOutput      = done_r;
   assign divByZeroOutput = dbz_r;
   assign hiOutput        = hi_reg;
   assign loOutput        = lo_reg;

endmodule
